// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction memory geometry and the program loader state type.
package cpu_pkg;

  localparam int unsigned INST_ADDR_WIDTH = 4;
  localparam int unsigned INST_DATA_WIDTH = 32;
  localparam int unsigned INST_DEPTH      = 1 << INST_ADDR_WIDTH;
  localparam int unsigned BYTES_PER_WORD  = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    START,
    RUN,
    ERROR
  } loader_state_e;

endpackage

// File: rtl/byte_packer.sv
// Collects little-endian bytes into 32-bit words; word_valid_c fires on the fourth accepted byte.
module byte_packer
  import cpu_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       accept,
  input  logic [7:0]                 byte_data,
  output logic [INST_DATA_WIDTH-1:0] word_c,
  output logic                       word_valid_c
);

  localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);
  localparam int unsigned LOW_W = INST_DATA_WIDTH - 8;

  logic [CNT_W-1:0] byte_cnt;
  logic [LOW_W-1:0] low_bytes;

  // Bytes enter at the top and shift down, so the first byte ends up in [7:0]
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt  <= '0;
      low_bytes <= '0;
    end else if (clr) begin
      byte_cnt  <= '0;
    end else if (accept) begin
      byte_cnt  <= byte_cnt + CNT_W'(1);
      low_bytes <= {byte_data, low_bytes[LOW_W-1:8]};
    end
  end

  assign word_c       = {byte_data, low_bytes};
  assign word_valid_c = accept && (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// Loads a CPU program from a byte stream into instruction memory, then releases and starts the CPU.
// Optional trailing checksum byte enabled by PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import cpu_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_req,
  input  logic [INST_ADDR_WIDTH-1:0] prog_len,
  input  logic                       byte_valid,
  input  logic [7:0]                 byte_data,
  output logic                       byte_ready,
  input  logic                       imem_en,
  input  logic [INST_ADDR_WIDTH-1:0] imem_addr,
  output logic [INST_DATA_WIDTH-1:0] imem_data,
  output logic                       cpu_rst,
  output logic                       cpu_start,
  output logic                       busy,
  output logic                       load_err
);

  localparam int unsigned AW = INST_ADDR_WIDTH;

  loader_state_e        state, next_state;
  logic [AW-1:0]        word_cnt, len_q;
  logic                 start_load_c, accept_c, pack_accept_c, last_word_c;
  logic                 word_valid_c;
  logic [INST_DATA_WIDTH-1:0] word_c;
  logic [INST_DATA_WIDTH-1:0] mem [INST_DEPTH];

  assign accept_c      = byte_valid && byte_ready;
  assign pack_accept_c = accept_c && (state == LOAD);
  // prog_len of 0 wraps to all-ones here, giving a full-depth load
  assign last_word_c   = (word_cnt == AW'(len_q - AW'(1)));

  byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clr          (start_load_c),
    .accept       (pack_accept_c),
    .byte_data    (byte_data),
    .word_c       (word_c),
    .word_valid_c (word_valid_c)
  );

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic       sum_ok_c;

  assign sum_ok_c = (8'(sum + byte_data) == 8'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum      <= '0;
      load_err <= 1'b0;
    end else begin
      load_err <= (next_state == ERROR);
      if (start_load_c)       sum <= '0;
      else if (pack_accept_c) sum <= 8'(sum + byte_data);
    end
  end
`else
  assign load_err = 1'b0;
`endif

  always_comb begin
    next_state   = state;
    start_load_c = 1'b0;
    unique case (state)
      IDLE, RUN, ERROR: begin
        if (load_req) begin
          next_state   = LOAD;
          start_load_c = 1'b1;
        end
      end
      LOAD: begin
        if (word_valid_c && last_word_c) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          next_state = CHECK;
`else
          next_state = START;
`endif
        end
      end
      CHECK: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        if (accept_c) next_state = sum_ok_c ? START : ERROR;
`else
        next_state = IDLE;
`endif
      end
      START:   next_state = RUN;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      word_cnt <= '0;
      len_q    <= '0;
    end else begin
      state <= next_state;
      if (start_load_c) begin
        word_cnt <= '0;
        len_q    <= prog_len;
      end else if (word_valid_c) begin
        word_cnt <= word_cnt + AW'(1);
      end
    end
  end

  // Outputs are registered from next_state so they always match the current state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rst    <= 1'b1;
      cpu_start  <= 1'b0;
      busy       <= 1'b0;
      byte_ready <= 1'b0;
    end else begin
      cpu_rst    <= !((next_state == START) || (next_state == RUN));
      cpu_start  <= (next_state == START);
      busy       <= (next_state == LOAD) || (next_state == CHECK);
      byte_ready <= (next_state == LOAD) || (next_state == CHECK);
    end
  end

  // Instruction array has no reset so contents survive reloads and resets
  always_ff @(posedge clk) begin
    if (word_valid_c) mem[word_cnt] <= word_c;
  end

  assign imem_data = (imem_en && (state == RUN)) ? mem[imem_addr] : '0;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected reads are queued by stimulus and checked by a monitor.
module tb_prog_loader;
  import cpu_pkg::*;

  localparam int unsigned AW = INST_ADDR_WIDTH;
  localparam int unsigned DW = INST_DATA_WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_req = 1'b0;
  logic [AW-1:0] prog_len = '0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = '0;
  logic          byte_ready;
  logic          imem_en = 1'b0;
  logic [AW-1:0] imem_addr = '0;
  logic [DW-1:0] imem_data;
  logic          cpu_rst, cpu_start, busy, load_err;

  int            n_cmp = 0;
  int            n_fail = 0;
  int            n_start = 0;
  int            n_acc = 0;
  int            s0, a0;
  logic [31:0]   exp_q[$];
  logic [31:0]   mon_exp;
  logic [7:0]    tb_sum = '0;
  logic [7:0]    basic_bytes[8];

  prog_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (load_req),
    .prog_len   (prog_len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .cpu_rst    (cpu_rst),
    .cpu_start  (cpu_start),
    .busy       (busy),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts start pulses and byte accepts, and scores every instruction read
  always @(negedge clk) begin
    if (cpu_start) n_start++;
    if (byte_valid && byte_ready) n_acc++;
    if (imem_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL imem_unexpected: got %h expected no read", imem_data);
      end else begin
        mon_exp = exp_q.pop_front();
        chk($sformatf("imem[%0d]", imem_addr), imem_data, mon_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [AW-1:0] len);
    prog_len = len;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    tb_sum   = '0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    byte_data  = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (byte_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL byte_timeout: got no accept expected accept of %h", b);
    end
    tb_sum = 8'(tb_sum + b);
  endtask

  task automatic finish_load();
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'(8'h00 - tb_sum));
`endif
    byte_valid = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] addr, input logic [31:0] exp);
    exp_q.push_back(exp);
    imem_addr = addr;
    imem_en   = 1'b1;
    tick();
    imem_en   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    basic_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    // Reset state
    @(negedge clk);
    chk("rst_cpu_rst",    32'(cpu_rst),    32'd1);
    chk("rst_cpu_start",  32'(cpu_start),  32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_load_err",   32'(load_err),   32'd0);
    chk("rst_byte_ready", 32'(byte_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Basic two-word load
    pulse_load(AW'(2));
    chk("load_busy",       32'(busy),       32'd1);
    chk("load_byte_ready", 32'(byte_ready), 32'd1);
    s0 = n_start;
    for (int i = 0; i < 8; i++) send_byte(basic_bytes[i]);
    finish_load();
    chk("start_pulse_high", 32'(cpu_start), 32'd1);
    tick();
    chk("start_pulse_low",  32'(cpu_start), 32'd0);
    chk("run_cpu_rst",      32'(cpu_rst),   32'd0);
    chk("run_busy",         32'(busy),      32'd0);
    chk("basic_start_count", 32'(n_start - s0), 32'd1);
    rd(AW'(0), 32'h44332211);
    rd(AW'(1), 32'h88776655);

    // Bytes offered in RUN are not taken
    a0 = n_acc;
    byte_data  = 8'h5A;
    byte_valid = 1'b1;
    repeat (3) tick();
    chk("run_byte_ready", 32'(byte_ready), 32'd0);
    byte_valid = 1'b0;
    chk("run_no_accept", 32'(n_acc - a0), 32'd0);

    // Reload from RUN with toggling valid and an ignored mid-load request
    pulse_load(AW'(1));
    chk("reload_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("reload_busy",    32'(busy),    32'd1);
    rd(AW'(0), 32'h0);
    a0 = n_acc;
    send_byte(8'hAA);
    byte_valid = 1'b0;
    tick();
    send_byte(8'hBB);
    byte_valid = 1'b0;
    prog_len   = AW'(3);
    load_req   = 1'b1;
    tick();
    load_req   = 1'b0;
    chk("ignored_req_busy", 32'(busy), 32'd1);
    send_byte(8'hCC);
    byte_valid = 1'b0;
    tick();
    send_byte(8'hDD);
    chk("backpressure_accepts", 32'(n_acc - a0), 32'd4);
    finish_load();
    tick();
    chk("reload_run_cpu_rst", 32'(cpu_rst), 32'd0);
    rd(AW'(0), 32'hDDCCBBAA);
    rd(AW'(1), 32'h88776655);

    // Reset in the middle of the second word
    pulse_load(AW'(2));
    send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C); send_byte(8'h0D);
    send_byte(8'h0E); send_byte(8'h0F);
    byte_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_cpu_rst",    32'(cpu_rst),    32'd1);
    chk("midrst_byte_ready", 32'(byte_ready), 32'd0);
    chk("midrst_busy",       32'(busy),       32'd0);
    tick();
    rst = 1'b0;
    tick();
    pulse_load(AW'(1));
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    finish_load();
    tick();
    rd(AW'(0), 32'h04030201);
    rd(AW'(1), 32'h88776655);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Bad checksum goes to ERROR; a new request recovers
    s0 = n_start;
    pulse_load(AW'(1));
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'hF5);
    byte_valid = 1'b0;
    chk("err_load_err",   32'(load_err),   32'd1);
    chk("err_cpu_rst",    32'(cpu_rst),    32'd1);
    chk("err_busy",       32'(busy),       32'd0);
    chk("err_byte_ready", 32'(byte_ready), 32'd0);
    tick();
    chk("err_no_start", 32'(n_start - s0), 32'd0);
    pulse_load(AW'(1));
    chk("err_exit_load_err", 32'(load_err), 32'd0);
    chk("err_exit_busy",     32'(busy),     32'd1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'hF6);
    byte_valid = 1'b0;
    tick();
    chk("good_sum_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("good_sum_start",   32'(n_start - s0), 32'd1);
`endif

    // Full-depth load
    s0 = n_start;
    pulse_load(AW'(0));
    for (int w = 0; w < int'(INST_DEPTH); w++)
      for (int k = 0; k < 4; k++) send_byte(8'(4 * w + k));
    chk("word_cnt_wrap", 32'(dut.word_cnt), 32'd0);
    finish_load();
    tick();
    chk("full_start_count", 32'(n_start - s0), 32'd1);
    rd(AW'(0),              32'h03020100);
    rd(AW'(7),              32'h1F1E1D1C);
    rd(AW'(INST_DEPTH - 1), 32'h3F3E3D3C);

    tick();
    tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
